// File: rtl/flex_pts_tx.sv
// Handshaked parallel-to-serial transmitter: one-word holding buffer feeding a
// strobe-paced shifter, gapless back-to-back words, synchronous abort.
module flex_pts_tx #(
  parameter int NUM_BITS  = 8,
  parameter bit SHIFT_MSB = 1'b1,
  parameter bit IDLE_VAL  = 1'b1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                shift_enable_i,
  input  logic                tx_valid_i,
  input  logic [NUM_BITS-1:0] tx_data_i,
  output logic                tx_ready_o,
  input  logic                abort_i,
  output logic                serial_out_o,
  output logic                busy_o,
  output logic                word_done_o
);

  localparam int CW = $clog2(NUM_BITS);
  localparam logic [CW-1:0] LAST_BIT = CW'(NUM_BITS - 1);
  localparam logic [NUM_BITS-1:0] IDLE_WORD = {NUM_BITS{IDLE_VAL}};

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t              state_q, state_d;
  logic [NUM_BITS-1:0] hold_q, hold_d;
  logic                hold_full_q, hold_full_d;
  logic [NUM_BITS-1:0] shift_q, shift_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                done_q, done_d;

  logic [NUM_BITS-1:0] shifted;
  logic                line_bit;

  if (SHIFT_MSB) begin : g_msb
    assign shifted  = {shift_q[NUM_BITS-2:0], IDLE_VAL};
    assign line_bit = shift_q[NUM_BITS-1];
  end else begin : g_lsb
    assign shifted  = {IDLE_VAL, shift_q[NUM_BITS-1:1]};
    assign line_bit = shift_q[0];
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;

    // Accept and load are mutually exclusive: accept needs an empty buffer,
    // load needs a full one (both judged on the registered flag).
    if (tx_valid_i && !hold_full_q) begin
      hold_d      = tx_data_i;
      hold_full_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (hold_full_q) begin
          shift_d     = hold_q;
          cnt_d       = '0;
          hold_full_d = 1'b0;
          state_d     = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (shift_enable_i) begin
          if (cnt_q == LAST_BIT) begin
            done_d = 1'b1;
            cnt_d  = '0;
            if (hold_full_q) begin
              shift_d     = hold_q;
              hold_full_d = 1'b0;
            end else begin
              // Refill with the idle level so the line bit is correct in IDLE.
              shift_d = IDLE_WORD;
              state_d = ST_IDLE;
            end
          end else begin
            shift_d = shifted;
            cnt_d   = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort_i) begin
      state_d     = ST_IDLE;
      hold_full_d = 1'b0;
      cnt_d       = '0;
      shift_d     = IDLE_WORD;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= IDLE_WORD;
      cnt_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
    end
  end

  assign serial_out_o = line_bit;
  assign busy_o       = (state_q == ST_SHIFT) || hold_full_q;
  assign word_done_o  = done_q;
  assign tx_ready_o   = !hold_full_q;

endmodule

// File: tb/tb_flex_pts_tx.sv
// Bench for flex_pts_tx: an MSB-first/idle-1 and an LSB-first/idle-0 instance
// share stimulus and are checked every cycle against a word-level model.
module tb_flex_pts_tx;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         se = 1'b0;
  logic         valid = 1'b0;
  logic         abort = 1'b0;
  logic [N-1:0] data = '0;

  logic ready_m, ser_m, busy_m, done_m;
  logic ready_l, ser_l, busy_l, done_l;

  int vectors = 0;
  int miscompares = 0;

  // Word-level model: an active word with a bit index, plus a pending word.
  bit           m_active = 1'b0;
  bit           m_hold_v = 1'b0;
  bit           m_done = 1'b0;
  logic [N-1:0] m_word = '0;
  logic [N-1:0] m_hold = '0;
  int           m_idx = 0;

  flex_pts_tx #(.NUM_BITS(N), .SHIFT_MSB(1'b1), .IDLE_VAL(1'b1)) dut_m (
    .clk(clk), .n_rst(n_rst), .shift_enable_i(se), .tx_valid_i(valid),
    .tx_data_i(data), .tx_ready_o(ready_m), .abort_i(abort),
    .serial_out_o(ser_m), .busy_o(busy_m), .word_done_o(done_m)
  );

  flex_pts_tx #(.NUM_BITS(N), .SHIFT_MSB(1'b0), .IDLE_VAL(1'b0)) dut_l (
    .clk(clk), .n_rst(n_rst), .shift_enable_i(se), .tx_valid_i(valid),
    .tx_data_i(data), .tx_ready_o(ready_l), .abort_i(abort),
    .serial_out_o(ser_l), .busy_o(busy_l), .word_done_o(done_l)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_line(input bit msb, input bit idle);
    if (!m_active) return idle;
    return msb ? m_word[N-1-m_idx] : m_word[m_idx];
  endfunction

  task automatic model_reset();
    m_active = 1'b0; m_hold_v = 1'b0; m_done = 1'b0; m_idx = 0;
  endtask

  task automatic model_edge();
    bit hv;
    if (!n_rst) begin
      model_reset();
    end else if (abort) begin
      model_reset();
    end else begin
      hv = m_hold_v;
      m_done = 1'b0;
      if (!m_active) begin
        if (hv) begin
          m_active = 1'b1; m_word = m_hold; m_idx = 0; m_hold_v = 1'b0;
        end
      end else if (se) begin
        if (m_idx == N - 1) begin
          m_done = 1'b1;
          if (hv) begin
            m_word = m_hold; m_idx = 0; m_hold_v = 1'b0;
          end else begin
            m_active = 1'b0;
          end
        end else begin
          m_idx++;
        end
      end
      if (valid && !hv) begin
        m_hold = data; m_hold_v = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/ser_m"},   N'(ser_m),   N'(exp_line(1'b1, 1'b1)));
    chk({tag, "/ser_l"},   N'(ser_l),   N'(exp_line(1'b0, 1'b0)));
    chk({tag, "/busy_m"},  N'(busy_m),  N'(m_active || m_hold_v));
    chk({tag, "/busy_l"},  N'(busy_l),  N'(m_active || m_hold_v));
    chk({tag, "/ready_m"}, N'(ready_m), N'(!m_hold_v));
    chk({tag, "/ready_l"}, N'(ready_l), N'(!m_hold_v));
    chk({tag, "/done_m"},  N'(done_m),  N'(m_done));
    chk({tag, "/done_l"},  N'(done_l),  N'(m_done));
  endtask

  // One clock: model follows the edge, outputs are checked on the falling edge.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic send(input logic [N-1:0] w);
    valid = 1'b1; data = w;
    step("send");
    valid = 1'b0;
  endtask

  // Strobe every 4 clocks, capturing the line bit present at each strobe.
  task automatic strobe_bits(input int n, output logic [N-1:0] cm, output logic [N-1:0] cl);
    cm = '0; cl = '0;
    for (int i = 0; i < n; i++) begin
      repeat (3) step("gap");
      cm = {cm[N-2:0], ser_m};
      cl = {ser_l, cl[N-1:1]};
      se = 1'b1;
      step("strobe");
      se = 1'b0;
    end
  endtask

  initial begin
    logic [N-1:0] cm, cl;

    repeat (3) step("reset");
    chk("rst_ser_m", N'(ser_m), N'(1'b1));
    chk("rst_ready_m", N'(ready_m), N'(1'b1));
    n_rst = 1'b1;
    se = 1'b1;
    repeat (3) step("idle_strobe");
    se = 1'b0;
    chk("idle_line_m", N'(ser_m), N'(1'b1));
    chk("idle_line_l", N'(ser_l), N'(1'b0));

    send(8'h1E);
    strobe_bits(N, cm, cl);
    chk("word_1e_m", cm, 8'h1E);
    chk("word_1e_l", cl, 8'h1E);
    chk("done_pulse_m", N'(done_m), N'(1'b1));
    step("after_1e");
    chk("after_1e_busy", N'(busy_m), N'(1'b0));
    chk("after_1e_ser", N'(ser_m), N'(1'b1));

    send(8'hA5);
    step("load_a5");
    send(8'h3C);
    chk("b2b_ready_low", N'(ready_m), N'(1'b0));
    strobe_bits(N, cm, cl);
    chk("b2b_word0_m", cm, 8'hA5);
    strobe_bits(N, cm, cl);
    chk("b2b_word1_m", cm, 8'h3C);
    chk("b2b_word1_l", cl, 8'h3C);
    step("b2b_tail");

    send(8'hF0);
    step("load_f0");
    send(8'h0F);
    strobe_bits(3, cm, cl);
    abort = 1'b1;
    step("abort");
    abort = 1'b0;
    chk("abort_ser", N'(ser_m), N'(1'b1));
    chk("abort_busy", N'(busy_m), N'(1'b0));
    chk("abort_ready", N'(ready_m), N'(1'b1));
    chk("abort_done", N'(done_m), N'(1'b0));
    send(8'h81);
    strobe_bits(N, cm, cl);
    chk("post_abort_81", cm, 8'h81);
    step("post_abort_tail");

    send(8'h55);
    strobe_bits(4, cm, cl);
    step("bit5");
    #2 n_rst = 1'b0;
    #1;
    model_reset();
    chk("async_ser_m", N'(ser_m), N'(1'b1));
    chk("async_ser_l", N'(ser_l), N'(1'b0));
    chk("async_busy", N'(busy_m), N'(1'b0));
    chk("async_ready", N'(ready_m), N'(1'b1));
    chk("async_done", N'(done_m), N'(1'b0));
    repeat (2) step("in_reset");
    n_rst = 1'b1;
    step("post_reset");

    for (int i = 0; i < 3000; i++) begin
      se    = ($urandom_range(0, 2) == 0);
      valid = ($urandom_range(0, 3) != 0);
      data  = N'($urandom);
      abort = ($urandom_range(0, 63) == 0);
      step("rand");
    end
    se = 1'b0; valid = 1'b0; abort = 1'b0;
    step("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
